// File: rtl/game_control.sv
// Game sequencing FSM: start on key, draw / frame hold / erase / step per animation step.
// Optional GAME_CONTROL_PAUSE_EN adds a pause input that freezes the frame hold.
//
// state     | meaning
// ----------+-------------------------------------------------------
// IDLE    0 | waiting for go press
// GO_WAIT 1 | waiting for go release; score cleared on exit
// DRAW    2 | draw burst, N pixels
// HOLD    3 | hold drawn frame for FRAME_CYCLES*FRAMES_PER_STEP cycles
// ERASE   4 | erase burst, N pixels in colour 0
// STEP    5 | one-cycle position step, score increment, finish sampled
// DONE    6 | game over, score held; go restarts
module game_control #(
  parameter int PIXELS_PER_OBJ  = 16,
  parameter int OBJ_COUNT       = 2,
  parameter int FRAME_CYCLES    = 833334,
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       go,
  input  logic       finish,
`ifdef GAME_CONTROL_PAUSE_EN
  input  logic       pause,
`endif
  output logic       draw,
  output logic       plot,
  output logic       erase,
  output logic       setoff,
  output logic       step,
  output logic [7:0] score,
  output logic [2:0] state
);

  localparam int N     = PIXELS_PER_OBJ * OBJ_COUNT;
  localparam int PIX_W = (N > 1) ? $clog2(N) : 1;
  localparam int FC_W  = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int FN_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(N - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FRAME_CYCLES - 1);
  localparam logic [FN_W-1:0]  FN_LAST  = FN_W'(FRAMES_PER_STEP - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GO_WAIT = 3'd1,
    S_DRAW    = 3'd2,
    S_HOLD    = 3'd3,
    S_ERASE   = 3'd4,
    S_STEP    = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [PIX_W-1:0]  pix_cnt;
  logic [FC_W-1:0]   frm_cyc;
  logic [FN_W-1:0]   frm_cnt;
  logic              hold_run;
  logic              frm_last;
  logic              hold_tc;
  logic              pix_last;

`ifdef GAME_CONTROL_PAUSE_EN
  assign hold_run = ~pause;
`else
  assign hold_run = 1'b1;
`endif

  assign pix_last = (pix_cnt == PIX_LAST);
  assign frm_last = (frm_cyc == FC_LAST);
  assign hold_tc  = frm_last && (frm_cnt == FN_LAST);

  // A paused hold never leaves HOLD, even when sitting on the terminal count.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (go)                  state_d = S_GO_WAIT;
      S_GO_WAIT: if (!go)                 state_d = S_DRAW;
      S_DRAW:    if (pix_last)            state_d = S_HOLD;
      S_HOLD:    if (hold_run && hold_tc) state_d = S_ERASE;
      S_ERASE:   if (pix_last)            state_d = S_STEP;
      S_STEP:    state_d = finish ? S_DONE : S_DRAW;
      S_DONE:    if (go)                  state_d = S_GO_WAIT;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      pix_cnt <= '0;
      frm_cyc <= '0;
      frm_cnt <= '0;
      score   <= '0;
    end else begin
      state_q <= state_d;
      // every state change clears the counters, so each burst and hold starts at zero
      if (state_d != state_q) begin
        pix_cnt <= '0;
        frm_cyc <= '0;
        frm_cnt <= '0;
      end else begin
        if (state_q == S_DRAW || state_q == S_ERASE)
          pix_cnt <= pix_cnt + 1'b1;
        if (state_q == S_HOLD && hold_run) begin
          if (frm_last) begin
            frm_cyc <= '0;
            frm_cnt <= frm_cnt + 1'b1;
          end else begin
            frm_cyc <= frm_cyc + 1'b1;
          end
        end
      end
      if (state_q == S_GO_WAIT && !go)
        score <= '0;
      else if (state_q == S_STEP && score != 8'hFF)
        score <= score + 1'b1;
    end
  end

  always_comb begin
    draw   = 1'b0;
    plot   = 1'b0;
    erase  = 1'b0;
    setoff = 1'b0;
    step   = 1'b0;
    case (state_q)
      S_DRAW: begin
        draw = 1'b1;
        plot = 1'b1;
      end
      S_HOLD:  setoff = 1'b1;
      S_ERASE: begin
        draw  = 1'b1;
        plot  = 1'b1;
        erase = 1'b1;
      end
      S_STEP:  step = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_game_control.sv
// Bench for game_control with N=32, FRAME_CYCLES=4, FRAMES_PER_STEP=2.
// A phase/age model is compared every cycle, plus directed literal expectations.
module tb_game_control;
  localparam int PPO      = 16;
  localparam int OC       = 2;
  localparam int FC       = 4;
  localparam int FPS      = 2;
  localparam int N        = PPO * OC;
  localparam int HOLD_LEN = FC * FPS;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  logic go     = 1'b0;
  logic finish = 1'b0;
`ifdef GAME_CONTROL_PAUSE_EN
  logic pause  = 1'b0;
`endif
  logic       draw, plot, erase, setoff, step;
  logic [7:0] score;
  logic [2:0] state;

  game_control #(
    .PIXELS_PER_OBJ(PPO), .OBJ_COUNT(OC), .FRAME_CYCLES(FC), .FRAMES_PER_STEP(FPS)
  ) dut (
    .clock(clock), .resetn(resetn), .go(go), .finish(finish),
`ifdef GAME_CONTROL_PAUSE_EN
    .pause(pause),
`endif
    .draw(draw), .plot(plot), .erase(erase), .setoff(setoff), .step(step),
    .score(score), .state(state)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: phase number, cycles spent in phase, unpaused hold cycles, score
  int m_s = 0, m_age = 0, m_held = 0, m_score = 0;
  bit chk_en = 1'b0;

  always @(posedge clock) begin
    int nx;
    bit paused;
`ifdef GAME_CONTROL_PAUSE_EN
    paused = pause;
`else
    paused = 1'b0;
`endif
    if (!resetn) begin
      m_s = 0; m_age = 0; m_held = 0; m_score = 0;
    end else begin
      nx = m_s;
      case (m_s)
        0: if (go) nx = 1;
        1: if (!go) begin nx = 2; m_score = 0; end
        2: if (m_age == N - 1) nx = 3;
        3: if (!paused) begin
             if (m_held == HOLD_LEN - 1) nx = 4;
             m_held++;
           end
        4: if (m_age == N - 1) nx = 5;
        5: begin
             if (m_score < 255) m_score++;
             nx = finish ? 6 : 2;
           end
        6: if (go) nx = 1;
        default: nx = 0;
      endcase
      if (nx != m_s) begin m_age = 0; m_held = 0; end
      else m_age++;
      m_s = nx;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("state",  int'(state),  m_s);
      check("draw",   int'(draw),   int'(m_s == 2 || m_s == 4));
      check("plot",   int'(plot),   int'(m_s == 2 || m_s == 4));
      check("erase",  int'(erase),  int'(m_s == 4));
      check("setoff", int'(setoff), int'(m_s == 3));
      check("step",   int'(step),   int'(m_s == 5));
      check("score",  int'(score),  m_score);
    end
  end

  // counts strobes from the current sample until (and including) the next step pulse
  task automatic measure(output int nd, output int ns, output int ne, output int nst);
    nd = 0; ns = 0; ne = 0; nst = 0;
    for (int i = 0; i < 400; i++) begin
      if (draw && plot && !erase) nd++;
      if (setoff) ns++;
      if (erase && draw && plot) ne++;
      if (step) begin nst++; break; end
      @(negedge clock);
    end
    if (nst == 0) check("measure_timeout", 0, 1);
  endtask

  initial begin
    int nd, ns, ne, nst, pre, strobes, nsteps, nh;
    bit seen;

    // 1: reset, start, one full step
    repeat (3) @(negedge clock);
    check("rst_state", int'(state), 0);
    check("rst_strobes", int'({draw, plot, erase, setoff, step}), 0);
    check("rst_score", int'(score), 0);
    resetn = 1'b1;
    chk_en = 1'b1;
    go = 1'b1;
    repeat (3) @(negedge clock);
    check("t1_go_wait", int'(state), 1);
    go = 1'b0;
    @(negedge clock);
    check("t1_draw_entry", int'(state), 2);
    measure(nd, ns, ne, nst);
    check("t1_draw_len", nd, 32);
    check("t1_hold_len", ns, 8);
    check("t1_erase_len", ne, 32);
    check("t1_step_len", nst, 1);
    @(negedge clock);
    check("t1_score", int'(score), 1);
    check("t1_back_to_draw", int'(state), 2);

    // 2: finish raised mid-DRAW of step 3
    measure(nd, ns, ne, nst);
    @(negedge clock);
    check("t2_score2", int'(score), 2);
    pre = 0;
    repeat (10) begin
      if (draw && !erase) pre++;
      @(negedge clock);
    end
    finish = 1'b1;
    measure(nd, ns, ne, nst);
    check("t2_draw_full", pre + nd, 32);
    check("t2_hold_full", ns, 8);
    check("t2_erase_full", ne, 32);
    @(negedge clock);
    check("t2_score3", int'(score), 3);
    check("t2_done", int'(state), 6);
    strobes = 0;
    repeat (100) begin
      @(negedge clock);
      strobes += int'(draw) + int'(plot) + int'(erase) + int'(setoff) + int'(step);
    end
    check("t2_done_quiet", strobes, 0);
    check("t2_done_score", int'(score), 3);

    // 3: restart from DONE
    finish = 1'b0;
    go = 1'b1;
    repeat (10) @(negedge clock);
    check("t3_go_wait", int'(state), 1);
    check("t3_score_held", int'(score), 3);
    go = 1'b0;
    @(negedge clock);
    check("t3_draw", int'(state), 2);
    check("t3_score0", int'(score), 0);

    // 4: reset at pixel 17 of ERASE
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (erase) begin seen = 1'b1; break; end
    end
    check("t4_erase_seen", int'(seen), 1);
    repeat (17) @(negedge clock);
    check("t4_erase_pix17", int'(erase), 1);
    resetn = 1'b0;
    @(negedge clock);
    check("t4_rst_state", int'(state), 0);
    check("t4_rst_strobes", int'({draw, plot, erase, setoff, step}), 0);
    check("t4_rst_score", int'(score), 0);
    resetn = 1'b1;
    repeat (20) @(negedge clock);
    check("t4_idle_stays", int'(state), 0);

    // 5: saturation over 300 steps
    go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    @(negedge clock);
    check("t5_draw", int'(state), 2);
    nsteps = 0;
    for (int i = 0; i < 300 * 73 + 500 && nsteps < 300; i++) begin
      @(negedge clock);
      if (step) nsteps++;
    end
    check("t5_steps", nsteps, 300);
    check("t5_score_sat", int'(score), 255);

    // 6: hold length, with a pause burst when the pause port exists
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (setoff) begin seen = 1'b1; break; end
    end
    check("t6_hold_seen", int'(seen), 1);
    nh = 0;
    for (int i = 0; i < 100; i++) begin
      if (!setoff) break;
      nh++;
`ifdef GAME_CONTROL_PAUSE_EN
      if (i == 2)  pause = 1'b1;
      if (i == 22) pause = 1'b0;
`endif
      @(negedge clock);
    end
`ifdef GAME_CONTROL_PAUSE_EN
    check("t6_hold_paused", nh, 28);
`else
    check("t6_hold_len", nh, 8);
`endif
    check("t6_after_hold", int'(state), 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
